// File: rtl/occ_pkg.sv
// Shared types and defaults for the distance occupancy filter.
package occ_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    ARRIVING = 2'd1,
    OCCUPIED = 2'd2,
    LEAVING  = 2'd3
  } occ_state_t;

  localparam logic [15:0] DEF_MAX_DIST    = 16'd400;
  localparam logic [15:0] DEF_NEAR_THRESH = 16'd30;
  localparam logic [15:0] DEF_FAR_THRESH  = 16'd50;
  localparam int unsigned DEF_CONFIRM_N   = 3;
  localparam int unsigned DEF_BROKEN_N    = 4;
  localparam int unsigned DEF_TIMEOUT     = 5_000_000;

  // Watchdog counter width: must be able to hold TIMEOUT_CYCLES itself.
  function automatic int wd_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dist_avg4.sv
// 4-entry moving average of good distance samples. The first sample into an
// empty (or invalidated) window fills all four slots so the average starts
// at the real distance rather than ramping up from zero.
module dist_avg4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        smp_vld_i,
  input  logic [15:0] smp_i,
  input  logic        prefill_i,
  output logic [15:0] avg_o,
  output logic        avg_vld_o
);

  logic [3:0][15:0] win_q, win_d;
  logic             empty_q;
  logic [17:0]      sum_d;
  logic [15:0]      avg_q;
  logic             vld_q;

  // Next window contents and the sum over it.
  always_comb begin
    win_d = win_q;
    if (smp_vld_i) begin
      if (empty_q || prefill_i) win_d = {4{smp_i}};
      else                      win_d = {win_q[2:0], smp_i};
    end
    sum_d = 18'(win_d[0]) + 18'(win_d[1]) + 18'(win_d[2]) + 18'(win_d[3]);
  end

  // Window, registered average and its one-cycle valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= '0;
      empty_q <= 1'b1;
      avg_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      win_q <= win_d;
      vld_q <= smp_vld_i;
      if (smp_vld_i) begin
        empty_q <= 1'b0;
        avg_q   <= 16'(sum_d >> 2);
      end
    end
  end

  assign avg_o     = avg_q;
  assign avg_vld_o = vld_q;

endmodule

// File: rtl/dist_occupancy_filter.sv
// Distance post-processing: sample qualification, averaging, fault
// detection (bad-sample run and silence watchdog) and a hysteretic
// occupancy FSM with an arrival counter.
module dist_occupancy_filter
  import occ_pkg::*;
#(
  parameter logic [15:0] MAX_DIST       = DEF_MAX_DIST,
  parameter logic [15:0] NEAR_THRESH    = DEF_NEAR_THRESH,
  parameter logic [15:0] FAR_THRESH     = DEF_FAR_THRESH,
  parameter int unsigned CONFIRM_N      = DEF_CONFIRM_N,
  parameter int unsigned BROKEN_N       = DEF_BROKEN_N,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [15:0] dist_data,
  input  logic        dist_valid,
  output logic [15:0] filt_dist,
  output logic        filt_valid,
  output logic        car_present,
  output logic        sensor_broken,
  output logic [1:0]  occ_state,
  output logic [7:0]  car_count
);

  localparam int             WDW    = wd_width(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);
  localparam logic [3:0]     CONF   = 4'(CONFIRM_N);
  localparam logic [3:0]     BRK    = 4'(BROKEN_N);

  logic             good, bad;
  logic [3:0]       bad_cnt_q, bad_cnt_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             brk_q, brk_d;
  logic [15:0]      avg;
  logic             avg_vld;
  occ_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       cc_q, cc_d;
  logic             near, far;

  assign good = dist_valid && (dist_data != 16'd0) && (dist_data <= MAX_DIST);
  assign bad  = dist_valid && !good;

  // Only good samples reach the window; a broken sensor invalidates it.
  dist_avg4 u_avg (
    .clk       (clk),
    .rst_n     (reset_l),
    .smp_vld_i (good),
    .smp_i     (dist_data),
    .prefill_i (brk_q),
    .avg_o     (avg),
    .avg_vld_o (avg_vld)
  );

  // Bad-run counter, silence watchdog and the broken flag they drive.
  // Any strobe clears the watchdog before it can hit its limit.
  always_comb begin
    bad_cnt_d = bad_cnt_q;
    if (good)                          bad_cnt_d = 4'd0;
    else if (bad && bad_cnt_q != 4'hF) bad_cnt_d = bad_cnt_q + 4'd1;

    wd_d = wd_q;
    if (dist_valid)          wd_d = '0;
    else if (wd_q != WD_MAX) wd_d = wd_q + WDW'(1);

    brk_d = brk_q;
    if (good)                                       brk_d = 1'b0;
    else if ((bad && bad_cnt_d >= BRK) || wd_d == WD_MAX) brk_d = 1'b1;
  end

  assign near = avg < NEAR_THRESH;
  assign far  = avg > FAR_THRESH;

  // Occupancy next state; frozen while the sensor is flagged broken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cc_d    = cc_q;
    if (avg_vld && !brk_q) begin
      case (state_q)
        EMPTY: if (near) begin
          state_d = ARRIVING;
          cnt_d   = 4'd1;
        end
        ARRIVING: if (near) begin
          if (cnt_q + 4'd1 == CONF) begin
            state_d = OCCUPIED;
            cnt_d   = 4'd0;
            cc_d    = cc_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = EMPTY;
          cnt_d   = 4'd0;
        end
        OCCUPIED: if (far) begin
          state_d = LEAVING;
          cnt_d   = 4'd1;
        end
        LEAVING: if (far) begin
          if (cnt_q + 4'd1 == CONF) begin
            state_d = EMPTY;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = OCCUPIED;
          cnt_d   = 4'd0;
        end
        default: begin
          state_d = EMPTY;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State registers for counters, fault flag and FSM.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bad_cnt_q <= 4'd0;
      wd_q      <= '0;
      brk_q     <= 1'b0;
      state_q   <= EMPTY;
      cnt_q     <= 4'd0;
      cc_q      <= 8'd0;
    end else begin
      bad_cnt_q <= bad_cnt_d;
      wd_q      <= wd_d;
      brk_q     <= brk_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cc_q      <= cc_d;
    end
  end

  assign filt_dist     = avg;
  assign filt_valid    = avg_vld;
  assign car_present   = (state_q == OCCUPIED) || (state_q == LEAVING);
  assign sensor_broken = brk_q;
  assign occ_state     = state_q;
  assign car_count     = cc_q;

endmodule
